gpu_pixel_pipe: RTL and testbench

// - Pipelined, parametrised pixel back-end: shade -> blend -> dither -> pack for NPIX pixels per beat.
// - Sits between the rasteriser/texture fetch and the VRAM write burst builder.
// - Adds valid/ready flow control, per-beat capture of GPU state and a per-pixel write enable.

---
 rtl/gpu_pixel_pipe.sv | 242 ++++++++++++++++++++++++
 tb/tb_gpu_pixel_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_pixel_pipe.sv
// gpu_pixel_pipe
// Pixel back-end between the rasteriser/texture fetch and the VRAM write
// burst builder. Each beat carries NPIX horizontally adjacent pixels and
// passes through three register stages:
//   S1 shade  : texel x gouraud modulation (or plain gouraud when untextured)
//   S2 blend  : semi-transparency against the VRAM background
//   S3 pack   : ordered dither, truncation to 5:5:5, mask bit
// One global stall holds every stage while the output register is full and
// the downstream side is not ready. The mode inputs are captured with the
// beat, so changing them mid-stream only affects later beats.
//
// Ports
//   clk, i_rst            clock, synchronous active-high reset
//   i_valid / o_ready     input beat handshake
//   i_noTexture, i_noblend, i_dither, i_transMode, i_forceMask
//                         per-beat render state
//   i_scrX, i_scrY        position of pixel 0 (i_scrX is a multiple of NPIX)
//   i_texel, i_transparent, i_gouraud, i_bg
//                         per-pixel source data, pixel k in slice k
//   i_checkMask           mask-test enable (only with the macro below)
//   o_valid / i_ready     output beat handshake
//   o_pixels, o_pixEn, o_x, o_y
//                         packed pixels, write enables and beat position
//
// Build option
//   GPU_PIXPIPE_MASKTEST_EN : adds i_checkMask; a pixel whose background has
//   bit 15 set is not written while i_checkMask is high.
module gpu_pixel_pipe #(
  parameter int NPIX = 2
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_noTexture,
  input  logic               i_noblend,
  input  logic               i_dither,
  input  logic [1:0]         i_transMode,
  input  logic               i_forceMask,
  input  logic [9:0]         i_scrX,
  input  logic [8:0]         i_scrY,
  input  logic [16*NPIX-1:0] i_texel,
  input  logic [NPIX-1:0]    i_transparent,
  input  logic [24*NPIX-1:0] i_gouraud,
  input  logic [16*NPIX-1:0] i_bg,
`ifdef GPU_PIXPIPE_MASKTEST_EN
  input  logic               i_checkMask,
`endif
  output logic               o_valid,
  input  logic               i_ready,
  output logic [16*NPIX-1:0] o_pixels,
  output logic [NPIX-1:0]    o_pixEn,
  output logic [9:0]         o_x,
  output logic [8:0]         o_y
);

  // Texel modulation: 0x80 in the gouraud channel is neutral, so the
  // product is scaled by 1/128 and saturated.
  function automatic logic [7:0] shade_ch(input logic [4:0] tex5,
                                          input logic [7:0] g8,
                                          input logic       no_tex);
    logic [15:0] prod;
    logic [7:0]  res;
    prod = {8'd0, tex5, 3'b000} * {8'd0, g8};
    if (no_tex)                 res = g8;
    else if (prod[15:7] > 9'd255) res = 8'hFF;
    else                        res = prod[14:7];
    return res;
  endfunction

  // Ten-bit arithmetic: bit 9 flags an underflow (mode 2), bit 8 an overflow.
  function automatic logic [7:0] blend_ch(input logic [7:0] s,
                                          input logic [4:0] bg5,
                                          input logic [1:0] mode,
                                          input logic       en);
    logic [9:0] b10;
    logic [9:0] sum;
    logic [7:0] res;
    b10 = {2'b00, bg5, 3'b000};
    case (mode)
      2'd0:    sum = (b10 + {2'b00, s}) >> 1;
      2'd1:    sum = b10 + {2'b00, s};
      2'd2:    sum = b10 - {2'b00, s};
      default: sum = b10 + {4'b0000, s[7:2]};
    endcase
    if (!en)         res = s;
    else if (sum[9]) res = 8'h00;
    else if (sum[8]) res = 8'hFF;
    else             res = sum[7:0];
    return res;
  endfunction

  // 4x4 ordered dither, offsets in the range -4..+3 (4-bit two's complement).
  function automatic logic [4:0] dither_ch(input logic [7:0] v,
                                           input logic [1:0] xi,
                                           input logic [1:0] yi,
                                           input logic       en);
    logic [3:0] d;
    logic [9:0] t;
    logic [4:0] res;
    case ({yi, xi})
      4'h0: d = 4'hC;  4'h1: d = 4'h0;  4'h2: d = 4'hD;  4'h3: d = 4'h1;
      4'h4: d = 4'h2;  4'h5: d = 4'hE;  4'h6: d = 4'h3;  4'h7: d = 4'hF;
      4'h8: d = 4'hD;  4'h9: d = 4'h1;  4'hA: d = 4'hC;  4'hB: d = 4'h0;
      4'hC: d = 4'h3;  4'hD: d = 4'hF;  4'hE: d = 4'h2;  default: d = 4'hE;
    endcase
    t = {2'b00, v} + {{6{d[3]}}, d};
    if (!en)       res = v[7:3];
    else if (t[9]) res = 5'd0;
    else if (t[8]) res = 5'd31;
    else           res = t[7:3];
    return res;
  endfunction

  // ---------------------------------------------------------------- state
  logic                   s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [NPIX-1:0][23:0]  s1_shade_reg;
  logic [NPIX-1:0][14:0]  s1_bg_reg;
  logic [NPIX-1:0]        s1_blend_en_reg, s1_bit15_reg, s1_pix_en_reg;
  logic                   s1_dither_reg;
  logic [1:0]             s1_mode_reg;
  logic [9:0]             s1_x_reg;
  logic [8:0]             s1_y_reg;
  logic [NPIX-1:0][23:0]  s2_color_reg;
  logic [NPIX-1:0]        s2_bit15_reg, s2_pix_en_reg;
  logic                   s2_dither_reg;
  logic [9:0]             s2_x_reg;
  logic [8:0]             s2_y_reg;
  logic [NPIX-1:0][15:0]  s3_pixels_reg;
  logic [NPIX-1:0]        s3_pix_en_reg;
  logic [9:0]             s3_x_reg;
  logic [8:0]             s3_y_reg;

  logic [NPIX-1:0][23:0]  shade_next;
  logic [NPIX-1:0][14:0]  bg_next;
  logic [NPIX-1:0]        blend_en_next, bit15_next, pix_en_next, bg_mask;
  logic [NPIX-1:0][23:0]  blend_next;
  logic [NPIX-1:0][15:0]  pack_next;
  logic                   advance;

  // The whole pipe moves together; it only stops when the output register
  // holds a beat the consumer has not taken.
  assign advance = !s3_valid_reg | i_ready;
  assign o_ready = advance;

  genvar gi, gc;
  generate
    for (gi = 0; gi < NPIX; gi++) begin : g_pix
      logic stp;
      assign stp         = i_texel[16*gi+15];
      assign bg_mask[gi] = i_bg[16*gi+15];
      assign bg_next[gi] = i_bg[16*gi +: 15];

      // Untextured primitives always blend; textured ones only where stp is set.
      assign blend_en_next[gi] = !i_noblend & (stp | i_noTexture);
      assign bit15_next[gi]    = i_forceMask | (!i_noTexture & stp);
`ifdef GPU_PIXPIPE_MASKTEST_EN
      assign pix_en_next[gi]   = !i_transparent[gi] & !(i_checkMask & bg_mask[gi]);
`else
      assign pix_en_next[gi]   = !i_transparent[gi];
`endif

      for (gc = 0; gc < 3; gc++) begin : g_ch
        assign shade_next[gi][8*gc +: 8] =
          shade_ch(i_texel[16*gi+5*gc +: 5], i_gouraud[24*gi+8*gc +: 8], i_noTexture);
        assign blend_next[gi][8*gc +: 8] =
          blend_ch(s1_shade_reg[gi][8*gc +: 8], s1_bg_reg[gi][5*gc +: 5],
                   s1_mode_reg, s1_blend_en_reg[gi]);
        // Low two bits of (x + k) pick the dither column; x is NPIX-aligned.
        assign pack_next[gi][5*gc +: 5] =
          dither_ch(s2_color_reg[gi][8*gc +: 8], s2_x_reg[1:0] + 2'(gi),
                    s2_y_reg[1:0], s2_dither_reg);
      end
      assign pack_next[gi][15] = s2_bit15_reg[gi];
    end
  endgenerate

`ifndef GPU_PIXPIPE_MASKTEST_EN
  // Background mask bits only matter for the mask test.
  logic unused_bg_mask;
  assign unused_bg_mask = ^bg_mask;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      s1_valid_reg    <= 1'b0;
      s1_shade_reg    <= '0;
      s1_bg_reg       <= '0;
      s1_blend_en_reg <= '0;
      s1_bit15_reg    <= '0;
      s1_pix_en_reg   <= '0;
      s1_dither_reg   <= 1'b0;
      s1_mode_reg     <= '0;
      s1_x_reg        <= '0;
      s1_y_reg        <= '0;
      s2_valid_reg    <= 1'b0;
      s2_color_reg    <= '0;
      s2_bit15_reg    <= '0;
      s2_pix_en_reg   <= '0;
      s2_dither_reg   <= 1'b0;
      s2_x_reg        <= '0;
      s2_y_reg        <= '0;
      s3_valid_reg    <= 1'b0;
      s3_pixels_reg   <= '0;
      s3_pix_en_reg   <= '0;
      s3_x_reg        <= '0;
      s3_y_reg        <= '0;
    end else if (advance) begin
      s1_valid_reg    <= i_valid;
      s1_shade_reg    <= shade_next;
      s1_bg_reg       <= bg_next;
      s1_blend_en_reg <= blend_en_next;
      s1_bit15_reg    <= bit15_next;
      s1_pix_en_reg   <= pix_en_next;
      s1_dither_reg   <= i_dither;
      s1_mode_reg     <= i_transMode;
      s1_x_reg        <= i_scrX;
      s1_y_reg        <= i_scrY;

      s2_valid_reg    <= s1_valid_reg;
      s2_color_reg    <= blend_next;
      s2_bit15_reg    <= s1_bit15_reg;
      s2_pix_en_reg   <= s1_pix_en_reg;
      s2_dither_reg   <= s1_dither_reg;
      s2_x_reg        <= s1_x_reg;
      s2_y_reg        <= s1_y_reg;

      s3_valid_reg    <= s2_valid_reg;
      s3_pixels_reg   <= pack_next;
      s3_pix_en_reg   <= s2_pix_en_reg;
      s3_x_reg        <= s2_x_reg;
      s3_y_reg        <= s2_y_reg;
    end
  end

  assign o_valid  = s3_valid_reg;
  assign o_pixels = s3_pixels_reg;
  assign o_pixEn  = s3_pix_en_reg;
  assign o_x      = s3_x_reg;
  assign o_y      = s3_y_reg;

endmodule

// File: tb/tb_gpu_pixel_pipe.sv
// Testbench for gpu_pixel_pipe (NPIX = 2): directed cases from the pixel
// rules, back-pressure, random traffic against a behavioural model, and a
// reset with beats in flight.
module tb_gpu_pixel_pipe;
  localparam int NPIX = 2;
  localparam int PW   = 16*NPIX;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_rst, i_valid, o_ready, i_noTexture, i_noblend, i_dither;
  logic [1:0]         i_transMode;
  logic               i_forceMask, o_valid, i_ready;
  logic [9:0]         i_scrX, o_x;
  logic [8:0]         i_scrY, o_y;
  logic [PW-1:0]      i_texel, i_bg, o_pixels;
  logic [NPIX-1:0]    i_transparent, o_pixEn;
  logic [24*NPIX-1:0] i_gouraud;
`ifdef GPU_PIXPIPE_MASKTEST_EN
  logic               i_checkMask;
`endif

  gpu_pixel_pipe #(.NPIX(NPIX)) dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_noTexture(i_noTexture), .i_noblend(i_noblend), .i_dither(i_dither),
    .i_transMode(i_transMode), .i_forceMask(i_forceMask),
    .i_scrX(i_scrX), .i_scrY(i_scrY), .i_texel(i_texel),
    .i_transparent(i_transparent), .i_gouraud(i_gouraud), .i_bg(i_bg),
`ifdef GPU_PIXPIPE_MASKTEST_EN
    .i_checkMask(i_checkMask),
`endif
    .o_valid(o_valid), .i_ready(i_ready), .o_pixels(o_pixels),
    .o_pixEn(o_pixEn), .o_x(o_x), .o_y(o_y)
  );

  typedef struct {
    logic notex, noblend, dither, force_mask, check_mask;
    logic [1:0] mode;
    logic [9:0] x;
    logic [8:0] y;
    logic [PW-1:0] texel, bg;
    logic [NPIX-1:0] trans;
    logic [24*NPIX-1:0] gouraud;
  } beat_t;

  typedef struct packed {
    logic [PW-1:0]   pix;
    logic [NPIX-1:0] en;
    logic [9:0]      x;
    logic [8:0]      y;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_pass = 0, n_fail = 0, n_emitted = 0;
  logic stall_prev = 1'b0;
  exp_t held;
  int dm [4][4] = '{'{-4, 0, -3, 1}, '{2, -2, 3, -1}, '{-3, 1, -4, 0}, '{3, -1, 2, -2}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  function automatic int clamp255(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  // Reference: each pixel computed from the rules with integer arithmetic.
  function automatic exp_t model(input beat_t b);
    exp_t e;
    int t5, g, bgc, s, v, pix, stp;
    e.x = b.x; e.y = b.y; e.pix = '0; e.en = '0;
    for (int k = 0; k < NPIX; k++) begin
      stp = int'(b.texel[16*k+15]);
      pix = 0;
      for (int c = 0; c < 3; c++) begin
        t5  = int'((b.texel >> (16*k + 5*c)) & 31);
        g   = int'((b.gouraud >> (24*k + 8*c)) & 255);
        bgc = int'((b.bg >> (16*k + 5*c)) & 31) * 8;
        s   = b.notex ? g : ((t5 * 8 * g / 128 > 255) ? 255 : t5 * 8 * g / 128);
        v   = s;
        if (!b.noblend && (stp == 1 || b.notex)) begin
          case (b.mode)
            2'd0: v = (bgc + s) / 2;
            2'd1: v = bgc + s;
            2'd2: v = bgc - s;
            default: v = bgc + s / 4;
          endcase
          v = clamp255(v);
        end
        if (b.dither) v = clamp255(v + dm[int'(b.y) % 4][(int'(b.x) + k) % 4]);
        pix = pix | ((v / 8) << (5*c));
      end
      if (b.force_mask || (!b.notex && stp == 1)) pix = pix | 32'h8000;
      e.pix[16*k +: 16] = 16'(pix);
      e.en[k] = !b.trans[k];
`ifdef GPU_PIXPIPE_MASKTEST_EN
      if (b.check_mask && b.bg[16*k+15]) e.en[k] = 1'b0;
`endif
    end
    return e;
  endfunction

  function automatic beat_t blank_beat();
    beat_t b;
    b.notex = 1'b0; b.noblend = 1'b1; b.dither = 1'b0; b.force_mask = 1'b0;
    b.check_mask = 1'b0; b.mode = 2'd0; b.x = '0; b.y = '0;
    b.texel = '0; b.bg = '0; b.trans = '0;
    for (int k = 0; k < NPIX; k++) b.gouraud[24*k +: 24] = 24'h808080;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.notex = 1'($urandom); b.noblend = 1'($urandom); b.dither = 1'($urandom);
    b.force_mask = 1'($urandom); b.check_mask = 1'($urandom);
    b.mode = 2'($urandom);
    b.x = 10'($urandom) & ~10'(NPIX-1);
    b.y = 9'($urandom);
    for (int k = 0; k < NPIX; k++) begin
      b.texel[16*k +: 16]   = 16'($urandom);
      b.bg[16*k +: 16]      = 16'($urandom);
      b.gouraud[24*k +: 24] = 24'($urandom);
      b.trans[k]            = ($urandom_range(0, 3) == 0);
    end
    return b;
  endfunction

  function automatic exp_t cur_out();
    exp_t e;
    e = {o_pixels, o_pixEn, o_x, o_y};
    return e;
  endfunction

  task automatic drive(input beat_t b);
    i_noTexture = b.notex; i_noblend = b.noblend; i_dither = b.dither;
    i_forceMask = b.force_mask; i_transMode = b.mode;
    i_scrX = b.x; i_scrY = b.y; i_texel = b.texel; i_bg = b.bg;
    i_transparent = b.trans; i_gouraud = b.gouraud;
`ifdef GPU_PIXPIPE_MASKTEST_EN
    i_checkMask = b.check_mask;
`endif
  endtask

  // One clock of streaming traffic: handshake rules, hold-while-stalled and
  // in-order scoreboard comparison, all sampled on the falling edge.
  task automatic step(input logic v, input logic r, input beat_t b, output logic acc);
    exp_t want;
    drive(b); i_valid = v; i_ready = r;
    @(negedge clk);
    check("ready_rule", 64'(o_ready), 64'(!o_valid | i_ready));
    if (stall_prev) begin
      check("stall_valid", 64'(o_valid), 64'(1));
      check("stall_hold", 64'(cur_out()), 64'(held));
    end
    if (o_valid && i_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        want = sb.pop_front();
        check("beat", 64'(cur_out()), 64'(want));
        n_emitted++;
      end
    end
    acc = i_valid & o_ready;
    if (acc) sb.push_back(model(b));
    stall_prev = o_valid & !i_ready;
    held = cur_out();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step(1'b0, 1'b1, blank_beat(), acc);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Single beat into an empty pipe; lat counts clock edges from the accepting
  // edge up to the one that raises o_valid.
  task automatic send_one(input beat_t b, output exp_t got, output int lat);
    drive(b); i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = cur_out();
    @(posedge clk); #1;
  endtask

  initial begin
    beat_t b;
    exp_t  got;
    int    lat, cyc, sent, cnt;
    logic  acc;

    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    drive(blank_beat());
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_pixels", 64'(o_pixels), 64'(0));
    check("rst_pixen", 64'(o_pixEn), 64'(0));
    check("rst_xy", 64'({o_x, o_y}), 64'(0));
    i_rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(o_ready), 64'(1));

    // Untextured full red, no dither.
    b = blank_beat(); b.notex = 1'b1; b.x = 10'd6; b.y = 9'd5;
    for (int k = 0; k < NPIX; k++) b.gouraud[24*k +: 24] = 24'h8080FF;
    send_one(b, got, lat);
    check("latency", 64'(lat), 64'(3));
    check("d1_r5_p0", 64'(got.pix[4:0]), 64'(31));
    check("d1_r5_p1", 64'(got.pix[20:16]), 64'(31));
    check("d1_pixen", 64'(got.en), 64'(2'b11));
    check("d1_x", 64'(got.x), 64'(6));
    check("d1_y", 64'(got.y), 64'(5));
    check("d1_model", 64'(got), 64'(model(b)));

    // Textured r5=16 with neutral and full gouraud.
    b = blank_beat(); b.texel = {NPIX{16'h0010}};
    send_one(b, got, lat);
    check("d2_r5_neutral", 64'(got.pix[4:0]), 64'(16));
    for (int k = 0; k < NPIX; k++) b.gouraud[24*k +: 24] = 24'h8080FF;
    send_one(b, got, lat);
    check("d3_r5_sat", 64'(got.pix[4:0]), 64'(31));

    // Mode 2 underflows to 0; stp-textured pixel carries bit15.
    b = blank_beat(); b.noblend = 1'b0; b.mode = 2'd2;
    b.texel = {NPIX{16'h801F}}; b.bg = {NPIX{16'h0004}};
    for (int k = 0; k < NPIX; k++) b.gouraud[24*k +: 24] = 24'h8080FF;
    send_one(b, got, lat);
    check("d4_r5_sub", 64'(got.pix[4:0]), 64'(0));
    check("d4_bit15", 64'(got.pix[15]), 64'(1));
    check("d4_model", 64'(got), 64'(model(b)));

    // Mode 1 overflows to 31.
    b = blank_beat(); b.notex = 1'b1; b.noblend = 1'b0; b.mode = 2'd1;
    b.bg = {NPIX{16'h001F}};
    send_one(b, got, lat);
    check("d5_r5_add", 64'(got.pix[4:0]), 64'(31));
    check("d5_bit15", 64'(got.pix[15]), 64'(0));

    // Dither row 0 across x = 0..3 for v = 0x0C and v = 0x04.
    for (int vi = 0; vi < 2; vi++) begin
      for (int xs = 0; xs < 4; xs += NPIX) begin
        b = blank_beat(); b.notex = 1'b1; b.dither = 1'b1; b.x = 10'(xs);
        for (int k = 0; k < NPIX; k++) b.gouraud[24*k +: 24] = (vi == 0) ? 24'h80800C : 24'h808004;
        send_one(b, got, lat);
        check("dither_p0", 64'(got.pix[4:0]), 64'((vi == 0) ? 1 : 0));
        check("dither_p1", 64'(got.pix[20:16]), 64'((vi == 0) ? 1 : 0));
      end
    end

    // Transparent pixel is disabled; forceMask sets bit15 everywhere.
    b = blank_beat(); b.notex = 1'b1; b.trans = 2'b10; b.force_mask = 1'b1;
    send_one(b, got, lat);
    check("d7_pixen", 64'(got.en), 64'(2'b01));
    check("d7_force", 64'({got.pix[31], got.pix[15]}), 64'(2'b11));

`ifdef GPU_PIXPIPE_MASKTEST_EN
    b = blank_beat(); b.check_mask = 1'b1; b.bg = {16'h0000, 16'h8000};
    send_one(b, got, lat);
    check("mask_pixen", 64'(got.en), 64'(2'b10));
`endif

    // Eight beats back to back with i_ready toggling every cycle.
    stall_prev = 1'b0; n_emitted = 0; sent = 0; cyc = 0;
    b = rand_beat();
    while (sent < 8 && cyc < 100) begin
      step(1'b1, (cyc % 2) == 0, b, acc);
      if (acc) begin
        sent++;
        b = rand_beat();
      end
      cyc++;
    end
    drain();
    check("bp_count", 64'(n_emitted), 64'(8));

    // Random valid/ready traffic.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rand_beat(), acc);
    drain();

    // Reset with three beats in flight: none may emerge afterwards.
    stall_prev = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_beat(), acc);
    check("inflight_valid", 64'(o_valid), 64'(1));
    check("inflight_ready", 64'(o_ready), 64'(0));
    i_valid = 1'b0; i_rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", 64'(o_valid), 64'(0));
    @(posedge clk); #1;
    i_rst = 1'b0; i_ready = 1'b1;
    sb.delete();
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_valid) cnt++;
    end
    check("post_rst_no_valid", 64'(cnt), 64'(0));

    b = rand_beat();
    send_one(b, got, lat);
    check("post_rst_latency", 64'(lat), 64'(3));
    check("post_rst_beat", 64'(got), 64'(model(b)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
